// File: rtl/demux_4bits_reg.sv
// Registered 1-to-4 demux: each accepted word is steered into a one-entry holding register per channel.
// Latency: 1 cycle from input transfer to out_valid; full throughput via same-edge load and drain.
// Backpressure: in_ready is combinational per selected channel only; `DEMUX_STATS_EN adds out_cnt.
module demux_4bits_reg #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [1:0]           in_sel,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [4*WIDTH-1:0]   out_data
`ifdef DEMUX_STATS_EN
    ,
    output logic [31:0]          out_cnt
`endif
);

    logic [3:0]       valid_q;
    logic [WIDTH-1:0] data_q [4];
    logic [3:0]       load;
    logic [3:0]       drain;

    // A full channel still accepts when its consumer drains on the same edge.
    assign in_ready = !valid_q[in_sel] || out_ready[in_sel];
    assign drain    = valid_q & out_ready;

    always_comb begin
        load = '0;
        if (in_valid && in_ready) begin
            load[in_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (load[i]) begin
                    data_q[i]  <= in_data;
                    valid_q[i] <= 1'b1;
                end else if (drain[i]) begin
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

    assign out_valid = valid_q;

    for (genvar g = 0; g < 4; g++) begin : g_out
        assign out_data[g*WIDTH +: WIDTH] = data_q[g];
    end

`ifdef DEMUX_STATS_EN
    logic [7:0] cnt_q [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (drain[i]) begin
                    cnt_q[i] <= cnt_q[i] + 8'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_cnt
        assign out_cnt[g*8 +: 8] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_demux_4bits_reg.sv
// Directed bench for demux_4bits_reg: reset, steering, back-pressure, independence, streaming, async reset.
// Inputs change 1ns after the rising edge; outputs are checked 2ns after it.
module tb_demux_4bits_reg;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [15:0] out_data;
`ifdef DEMUX_STATS_EN
    logic [31:0] out_cnt;
`endif

    int passed = 0;
    int total  = 0;

    demux_4bits_reg #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef DEMUX_STATS_EN
        ,
        .out_cnt   (out_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [3:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        #1;
    endtask

    initial begin
        logic [3:0] word;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = 4'd0;
        out_ready = 4'b0000;

        // Reset state
        tick(); tick();
        #1;
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_data", 32'(out_data), 32'h0);
        check("rst_ready", 32'(in_ready), 32'h1);
`ifdef DEMUX_STATS_EN
        check("rst_cnt", out_cnt, 32'h0);
`endif
        tick();
        rst_n = 1'b1;

        // Basic steering, all consumers ready
        out_ready = 4'b1111;
        drive(1'b1, 2'd0, 4'b0101);
        check("steer_rdy0", 32'(in_ready), 32'h1);
        tick();
        drive(1'b1, 2'd1, 4'b1001);
        check("steer_v0", 32'(out_valid), 32'h1);
        check("steer_d0", 32'(out_data[3:0]), 32'h5);
        check("steer_rdy1", 32'(in_ready), 32'h1);
        tick();
        drive(1'b1, 2'd2, 4'b0011);
        check("steer_v1", 32'(out_valid), 32'h2);
        check("steer_d1", 32'(out_data[7:4]), 32'h9);
        check("steer_rdy2", 32'(in_ready), 32'h1);
        tick();
        drive(1'b1, 2'd3, 4'b0001);
        check("steer_v2", 32'(out_valid), 32'h4);
        check("steer_d2", 32'(out_data[11:8]), 32'h3);
        check("steer_rdy3", 32'(in_ready), 32'h1);
        tick();
        drive(1'b0, 2'd0, 4'd0);
        check("steer_v3", 32'(out_valid), 32'h8);
        check("steer_d3", 32'(out_data[15:12]), 32'h1);
        tick();
        check("steer_idle", 32'(out_valid), 32'h0);

        // Back-pressure on channel b
        out_ready = 4'b1101;
        drive(1'b1, 2'd1, 4'b1001);
        check("bp_rdy_first", 32'(in_ready), 32'h1);
        tick();
        drive(1'b1, 2'd1, 4'b1111);
        check("bp_rdy_blocked", 32'(in_ready), 32'h0);
        check("bp_v_hold", 32'(out_valid), 32'h2);
        check("bp_d_hold", 32'(out_data[7:4]), 32'h9);
        tick();
        check("bp_rdy_still", 32'(in_ready), 32'h0);
        check("bp_d_still", 32'(out_data[7:4]), 32'h9);
        out_ready = 4'b1111;
        #1;
        check("bp_rdy_release", 32'(in_ready), 32'h1);
        tick();
        drive(1'b0, 2'd0, 4'd0);
        check("bp_v_new", 32'(out_valid), 32'h2);
        check("bp_d_new", 32'(out_data[7:4]), 32'hF);
        tick();
        check("bp_drained", 32'(out_valid), 32'h0);

        // Independence: b stalled and full, c still accepts
        out_ready = 4'b1101;
        drive(1'b1, 2'd1, 4'b0110);
        tick();
        drive(1'b1, 2'd2, 4'b1010);
        check("ind_rdy_c", 32'(in_ready), 32'h1);
        tick();
        drive(1'b0, 2'd0, 4'd0);
        check("ind_v", 32'(out_valid), 32'h6);
        check("ind_d_b", 32'(out_data[7:4]), 32'h6);
        check("ind_d_c", 32'(out_data[11:8]), 32'hA);
        tick();
        check("ind_v_after", 32'(out_valid), 32'h2);
        check("ind_b_kept", 32'(out_data[7:4]), 32'h6);
        out_ready = 4'b1111;
        tick();
        check("ind_drained", 32'(out_valid), 32'h0);

        // Back-to-back stream to channel d with simultaneous load and drain
        for (int k = 0; k <= 8; k++) begin
            word = 4'(2 * k + 1);
            if (k < 8) begin
                drive(1'b1, 2'd3, word);
                check($sformatf("stream_rdy%0d", k), 32'(in_ready), 32'h1);
            end else begin
                drive(1'b0, 2'd0, 4'd0);
            end
            if (k > 0) begin
                check($sformatf("stream_v%0d", k), 32'(out_valid), 32'h8);
                check($sformatf("stream_d%0d", k), 32'(out_data[15:12]), 32'(2 * k - 1));
            end
            tick();
        end
        check("stream_end", 32'(out_valid), 32'h0);

        // Asynchronous reset mid-cycle with all channels full
        out_ready = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 2'(k), 4'(k + 12));
            tick();
        end
        drive(1'b0, 2'd0, 4'd0);
        check("full_v", 32'(out_valid), 32'hF);
        check("full_d", 32'(out_data), 32'hFEDC);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_v", 32'(out_valid), 32'h0);
        check("arst_d", 32'(out_data), 32'h0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_sel = 2'(k);
            #1;
            check($sformatf("arst_rdy%0d", k), 32'(in_ready), 32'h1);
        end

`ifdef DEMUX_STATS_EN
        // 257 deliveries on channel a wrap the counter to 1
        out_ready = 4'b1111;
        for (int k = 0; k < 257; k++) begin
            drive(1'b1, 2'd0, 4'(k));
            tick();
        end
        drive(1'b0, 2'd0, 4'd0);
        tick();
        check("stats_cnt", out_cnt, 32'h0000_0001);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
